clock_core_multi: RTL and testbench
===================================

Name: clock_core_multi

Overview:
- Parametrised time-of-day core: HH:MM:SS counter, NUM_ALARMS programmable alarms, ring/snooze/dismiss state machine.
- Successor to the single-alarm running-clock logic; supplies time to seg7 display and ring to the music/buzzer driver.
- Key-scan/control logic drives the set and alarm-write ports.

Parameters:
- CLK_FREQ, 50000000, clock cycles per second. Benches use a small value, e.g. 10.
- NUM_ALARMS, 4, number of alarm slots, 1..16.
- RING_SECS, 30, seconds ring stays high before auto-timeout, 1..255.
- SNOOZE_MIN, 5, snooze delay in minutes, 1..59.
- AW, derived = max(1, clog2(NUM_ALARMS)), alarm index width.

Ports:
- clk_50Mhz  in  1  system clock
- rst_n  in  1  synchronous reset, active-high (1 = reset; legacy name kept)
- stop  in  1  level; 1 freezes time increment
- set_time  in  1  pulse; load hou_in/min_in/sec_in
- hou_in  in  6  hours to load, 0..23
- min_in  in  6  minutes to load, 0..59
- sec_in  in  6  seconds to load, 0..59
- alarm_wr  in  1  pulse; write alarm slot alarm_idx
- alarm_idx  in  AW  slot to write
- alarm_hou  in  6  alarm hours
- alarm_min  in  6  alarm minutes
- alarm_en_in  in  1  enable for written slot
- snooze  in  1  pulse
- dismiss  in  1  pulse
- hou  out  6  current hours
- min  out  6  current minutes
- sec  out  6  current seconds
- tick_1hz  out  1  one-cycle pulse on each time increment
- ring  out  1  alarm sounding
- ring_idx  out  AW  slot that caused the current ring
- alarm_en  out  NUM_ALARMS  per-slot enable bits
- set_err  out  1  one-cycle pulse on a rejected set/write

Behaviour:
- Reset: time 00:00:00; prescaler 0; all alarm slots 00:00, disabled; FSM IDLE; ring=0, ring_idx=0, tick_1hz=0, set_err=0. All outputs registered.
- Prescaler:
  - Counts 0..CLK_FREQ-1 continuously, ignoring stop.
  - Wrap cycle = base tick.
  - On a base tick with stop=0: time increments and tick_1hz=1 on the next cycle.
- Increment:
  - sec 59->0 carries to min.
  - min 59->0 carries to hou.
  - hou 23->0.
- set_time:
  - Valid only if hou_in<=23, min_in<=59 and sec_in<=59.
  - Valid: load the time and clear the prescaler to 0. Set beats a same-cycle tick; no increment that cycle.
  - Invalid: time unchanged; set_err pulses one cycle.
- alarm_wr:
  - Valid only if alarm_idx<NUM_ALARMS, alarm_hou<=23 and alarm_min<=59; else set_err pulses.
  - Writes hou, min and enable of the slot. Takes effect for matches evaluated from the next cycle.
- Match:
  - Evaluated only on a cycle where time was just incremented, or just loaded by set_time.
  - Requires the new time to have sec==0, and hou/min equal to an enabled slot.
  - Several slots match: lowest index wins.
  - Only acted on in IDLE.
- FSM states:
  - IDLE:
    - On match: go to RINGING, ring_idx = winning slot, ring-second counter = 0.
    - ring rises on the cycle after the time update.
  - RINGING (ring=1):
    - Counter increments on every base tick, stop ignored. At RING_SECS: go to IDLE, ring=0.
    - dismiss: go to IDLE.
    - snooze: go to SNOOZED. Target = current hou:min + SNOOZE_MIN, wrapping min 60 and hour 24.
    - dismiss and snooze in the same cycle: dismiss wins.
  - SNOOZED (ring=0):
    - When time reaches target hh:mm:00 via increment or set: go to RINGING, counter cleared, ring_idx kept.
    - dismiss: go to IDLE.
    - snooze is ignored.
    - New alarm matches are ignored.
- Rewriting or disabling the ringing/snoozed slot does not abort the ring or snooze.
- set_time while SNOOZED keeps the target.
- rst_n mid-operation returns everything to reset values on the next edge, including alarm slots.

Test Plan:
- CLK_FREQ=10, reset then run 10 cycles -> tick_1hz one pulse, sec=1. Set 23:59:59 and wait one tick -> 00:00:00.
- set_time with min_in=60 -> set_err pulse, time unchanged. Valid set 12:34:56 coincident with a base tick -> reads 12:34:56, prescaler restarts at 0.
- Slot0=07:00 and slot2=07:00 enabled, set 06:59:59, one tick -> ring=1 on the cycle after sec=0, ring_idx=0. RING_SECS later -> ring=0.
- Ringing from 23:58, snooze -> ring=0, state SNOOZED, target 00:03 (SNOOZE_MIN=5). Advance to 00:03:00 -> ring=1 again.
- Ringing with dismiss and snooze in the same cycle -> IDLE, ring=0. A different enabled alarm matching while RINGING -> ignored, ring_idx unchanged.
- stop=1 while ringing -> time frozen, ring still times out after RING_SECS. alarm_wr with alarm_idx>=NUM_ALARMS (NUM_ALARMS=3) -> set_err, no slot changes.

Source files
------------

// File: rtl/clock_core_multi.sv
// rtl/clock_core_multi.sv - time-of-day counter with multiple alarms and a ring/snooze/dismiss controller
//
// Ports:
//   clk_50Mhz   system clock
//   rst_n       synchronous reset, active-high (legacy name)
//   stop        level, freezes time increment (prescaler keeps running)
//   set_time    pulse, load hou_in/min_in/sec_in when all fields are in range
//   alarm_wr    pulse, write hour/minute/enable of slot alarm_idx
//   snooze      pulse, defer a ringing alarm by SNOOZE_MIN minutes
//   dismiss     pulse, silence a ringing or snoozed alarm
//   hou/min/sec current time
//   tick_1hz    one-cycle pulse per time increment
//   ring        alarm sounding; ring_idx is the slot that caused it
//   alarm_en    per-slot enable bits
//   set_err     one-cycle pulse on a rejected set_time or alarm_wr
module clock_core_multi #(
   parameter int CLK_FREQ   = 50000000,
   parameter int NUM_ALARMS = 4,
   parameter int RING_SECS  = 30,
   parameter int SNOOZE_MIN = 5,
   parameter int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk_50Mhz,
   input  logic                  rst_n,
   input  logic                  stop,
   input  logic                  set_time,
   input  logic [5:0]            hou_in,
   input  logic [5:0]            min_in,
   input  logic [5:0]            sec_in,
   input  logic                  alarm_wr,
   input  logic [AW-1:0]         alarm_idx,
   input  logic [5:0]            alarm_hou,
   input  logic [5:0]            alarm_min,
   input  logic                  alarm_en_in,
   input  logic                  snooze,
   input  logic                  dismiss,
   output logic [5:0]            hou,
   output logic [5:0]            min,
   output logic [5:0]            sec,
   output logic                  tick_1hz,
   output logic                  ring,
   output logic [AW-1:0]         ring_idx,
   output logic [NUM_ALARMS-1:0] alarm_en,
   output logic                  set_err
);

   localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] psc;
   logic          base_tick, set_ok, wr_ok;
   logic          upd;          // time was incremented or loaded on the previous edge
   logic          at_top;       // freshly updated time sits on hh:mm:00
   logic [5:0]    al_hou [NUM_ALARMS];
   logic [5:0]    al_min [NUM_ALARMS];
   logic          hit;
   logic [AW-1:0] hit_idx, ring_idx_nx;
   logic [7:0]    ring_cnt, ring_cnt_nx;
   logic [5:0]    tgt_hou, tgt_min, tgt_hou_nx, tgt_min_nx;
   logic [6:0]    min_sum;
   logic [5:0]    snz_hou, snz_min;

   assign base_tick = (psc == PW'(CLK_FREQ - 1));
   assign set_ok    = set_time && (hou_in <= 6'd23) && (min_in <= 6'd59) && (sec_in <= 6'd59);
   assign wr_ok     = alarm_wr && (int'(alarm_idx) < NUM_ALARMS) &&
                      (alarm_hou <= 6'd23) && (alarm_min <= 6'd59);
   assign at_top    = upd && (sec == 6'd0);

   // Time, prescaler and alarm slot storage
   always_ff @(posedge clk_50Mhz) begin
      if (rst_n) begin
         psc      <= '0;
         hou      <= '0;
         min      <= '0;
         sec      <= '0;
         tick_1hz <= 1'b0;
         upd      <= 1'b0;
         set_err  <= 1'b0;
         alarm_en <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            al_hou[i] <= '0;
            al_min[i] <= '0;
         end
      end else begin
         tick_1hz <= 1'b0;
         upd      <= 1'b0;
         set_err  <= (set_time && !set_ok) || (alarm_wr && !wr_ok);
         if (set_ok) begin
            // a load overrides a coincident base tick and restarts the second
            hou <= hou_in;
            min <= min_in;
            sec <= sec_in;
            psc <= '0;
            upd <= 1'b1;
         end else begin
            psc <= base_tick ? '0 : psc + 1'b1;
            if (base_tick && !stop) begin
               tick_1hz <= 1'b1;
               upd      <= 1'b1;
               if (sec == 6'd59) begin
                  sec <= 6'd0;
                  if (min == 6'd59) begin
                     min <= 6'd0;
                     hou <= (hou == 6'd23) ? 6'd0 : hou + 6'd1;
                  end else begin
                     min <= min + 6'd1;
                  end
               end else begin
                  sec <= sec + 6'd1;
               end
            end
         end
         if (wr_ok) begin
            al_hou[alarm_idx]   <= alarm_hou;
            al_min[alarm_idx]   <= alarm_min;
            alarm_en[alarm_idx] <= alarm_en_in;
         end
      end
   end

   // Lowest enabled slot matching the current hh:mm wins
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (alarm_en[i] && (al_hou[i] == hou) && (al_min[i] == min)) begin
            hit     = 1'b1;
            hit_idx = AW'(i);
         end
      end
   end

   // Snooze target, wrapping minutes at 60 and hours at 24
   assign min_sum = {1'b0, min} + 7'(SNOOZE_MIN);
   always_comb begin
      snz_min = min_sum[5:0];
      snz_hou = hou;
      if (min_sum >= 7'd60) begin
         snz_min = 6'(min_sum - 7'd60);
         snz_hou = (hou == 6'd23) ? 6'd0 : hou + 6'd1;
      end
   end

   always_comb begin
      state_nx    = state;
      ring_idx_nx = ring_idx;
      ring_cnt_nx = ring_cnt;
      tgt_hou_nx  = tgt_hou;
      tgt_min_nx  = tgt_min;
      case (state)
         IDLE: begin
            if (at_top && hit) begin
               state_nx    = RINGING;
               ring_idx_nx = hit_idx;
               ring_cnt_nx = 8'd0;
            end
         end
         RINGING: begin
            if (dismiss) begin
               state_nx = IDLE;
            end else if (snooze) begin
               state_nx   = SNOOZED;
               tgt_hou_nx = snz_hou;
               tgt_min_nx = snz_min;
            end else if (base_tick) begin
               // ring timeout counts real seconds even while time is stopped
               if (ring_cnt == 8'(RING_SECS - 1)) begin
                  state_nx = IDLE;
               end else begin
                  ring_cnt_nx = ring_cnt + 8'd1;
               end
            end
         end
         SNOOZED: begin
            if (dismiss) begin
               state_nx = IDLE;
            end else if (at_top && (hou == tgt_hou) && (min == tgt_min)) begin
               state_nx    = RINGING;
               ring_cnt_nx = 8'd0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_50Mhz) begin
      if (rst_n) begin
         state    <= IDLE;
         ring     <= 1'b0;
         ring_idx <= '0;
         ring_cnt <= '0;
         tgt_hou  <= '0;
         tgt_min  <= '0;
      end else begin
         state    <= state_nx;
         ring     <= (state_nx == RINGING);
         ring_idx <= ring_idx_nx;
         ring_cnt <= ring_cnt_nx;
         tgt_hou  <= tgt_hou_nx;
         tgt_min  <= tgt_min_nx;
      end
   end

endmodule

// File: tb/tb_clock_core_multi.sv
// tb/tb_clock_core_multi.sv - self-checking bench for clock_core_multi against a seconds-of-day reference model
module tb_clock_core_multi;

   localparam int CLK = 10;
   localparam int NA  = 3;
   localparam int RS  = 3;
   localparam int SZ  = 5;

   logic          clk_50Mhz = 1'b0;
   logic          rst_n, stop, set_time, alarm_wr, alarm_en_in, snooze, dismiss;
   logic [5:0]    hou_in, min_in, sec_in, alarm_hou, alarm_min;
   logic [1:0]    alarm_idx;
   logic [5:0]    hou, min, sec;
   logic          tick_1hz, ring, set_err;
   logic [1:0]    ring_idx;
   logic [NA-1:0] alarm_en;

   int n_vec = 0;
   int n_err = 0;

   clock_core_multi #(.CLK_FREQ(CLK), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SZ)) dut (
      .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .stop(stop), .set_time(set_time),
      .hou_in(hou_in), .min_in(min_in), .sec_in(sec_in),
      .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hou(alarm_hou),
      .alarm_min(alarm_min), .alarm_en_in(alarm_en_in),
      .snooze(snooze), .dismiss(dismiss),
      .hou(hou), .min(min), .sec(sec), .tick_1hz(tick_1hz), .ring(ring),
      .ring_idx(ring_idx), .alarm_en(alarm_en), .set_err(set_err)
   );

   always #5 clk_50Mhz = ~clk_50Mhz;

   // Reference model: time as seconds of day, alarms as minute of day
   int m_tod, m_psc, m_mode, m_ridx, m_rticks, m_tgt;   // mode 0 idle, 1 ringing, 2 snoozed
   bit m_fresh, m_tick, m_err;
   int m_ahm [NA];
   bit m_aen [NA];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit base, sok, wok, top;
      int cur, win;
      if (rst_n) begin
         m_tod = 0; m_psc = 0; m_mode = 0; m_ridx = 0; m_rticks = 0; m_tgt = 0;
         m_fresh = 0; m_tick = 0; m_err = 0;
         for (int i = 0; i < NA; i++) begin m_ahm[i] = 0; m_aen[i] = 0; end
         return;
      end
      base = (m_psc == CLK - 1);
      sok  = set_time && hou_in < 24 && min_in < 60 && sec_in < 60;
      wok  = alarm_wr && alarm_idx < NA && alarm_hou < 24 && alarm_min < 60;
      cur  = m_tod / 60;
      top  = m_fresh && (m_tod % 60 == 0);
      if (m_mode == 0) begin
         win = -1;
         if (top)
            for (int i = 0; i < NA; i++)
               if (win < 0 && m_aen[i] && m_ahm[i] == cur) win = i;
         if (win >= 0) begin m_mode = 1; m_ridx = win; m_rticks = 0; end
      end else if (m_mode == 1) begin
         if (dismiss) m_mode = 0;
         else if (snooze) begin m_mode = 2; m_tgt = (cur + SZ) % 1440; end
         else if (base) begin
            m_rticks++;
            if (m_rticks >= RS) m_mode = 0;
         end
      end else begin
         if (dismiss) m_mode = 0;
         else if (top && cur == m_tgt) begin m_mode = 1; m_rticks = 0; end
      end
      m_err   = (set_time && !sok) || (alarm_wr && !wok);
      m_tick  = 0;
      m_fresh = 0;
      if (sok) begin
         m_tod = hou_in * 3600 + min_in * 60 + sec_in;
         m_psc = 0;
         m_fresh = 1;
      end else begin
         m_psc = base ? 0 : m_psc + 1;
         if (base && !stop) begin
            m_tod = (m_tod + 1) % 86400;
            m_tick = 1;
            m_fresh = 1;
         end
      end
      if (wok) begin
         m_ahm[alarm_idx] = alarm_hou * 60 + alarm_min;
         m_aen[alarm_idx] = alarm_en_in;
      end
   endtask

   task automatic compare_all();
      logic [NA-1:0] ae;
      for (int i = 0; i < NA; i++) ae[i] = m_aen[i];
      check("hou", hou, m_tod / 3600);
      check("min", min, (m_tod / 60) % 60);
      check("sec", sec, m_tod % 60);
      check("tick_1hz", tick_1hz, m_tick);
      check("ring", ring, m_mode == 1);
      check("ring_idx", ring_idx, m_ridx);
      check("alarm_en", alarm_en, ae);
      check("set_err", set_err, m_err);
   endtask

   task automatic step();
      @(posedge clk_50Mhz);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_set(input int h, input int m, input int s);
      set_time = 1'b1; hou_in = 6'(h); min_in = 6'(m); sec_in = 6'(s);
      step();
      set_time = 1'b0;
   endtask

   task automatic do_wr(input int idx, input int h, input int m, input bit en);
      alarm_wr = 1'b1; alarm_idx = 2'(idx); alarm_hou = 6'(h); alarm_min = 6'(m); alarm_en_in = en;
      step();
      alarm_wr = 1'b0;
   endtask

   function automatic int pick_hou();
      case ($urandom_range(0, 4))
         0: return 0;
         1: return 6;
         2: return 7;
         3: return 23;
         default: return $urandom_range(0, 31);
      endcase
   endfunction

   function automatic int pick_min();
      case ($urandom_range(0, 3))
         0: return $urandom_range(0, 4);
         1: return $urandom_range(55, 59);
         2: return 60;
         default: return $urandom_range(0, 63);
      endcase
   endfunction

   int cnt, budget;

   initial begin
      rst_n = 1'b1; stop = 1'b0; set_time = 1'b0; alarm_wr = 1'b0; alarm_en_in = 1'b0;
      snooze = 1'b0; dismiss = 1'b0; hou_in = '0; min_in = '0; sec_in = '0;
      alarm_hou = '0; alarm_min = '0; alarm_idx = '0;
      step(); step();
      check("rst_sec", sec, 0);
      check("rst_ring", ring, 0);
      check("rst_alarm_en", alarm_en, 0);
      rst_n = 1'b0;

      // first second after reset
      cnt = 0;
      repeat (10) begin step(); cnt += tick_1hz; end
      check("first_ticks", cnt, 1);
      check("first_sec", sec, 1);

      // midnight wrap
      do_set(23, 59, 59);
      budget = 12;
      do begin step(); budget--; end while (!tick_1hz && budget > 0);
      check("wrap_tick_seen", tick_1hz, 1);
      check("wrap_hms", {hou, min, sec}, 18'd0);

      // rejected set
      do_set(1, 60, 0);
      check("bad_set_err", set_err, 1);
      check("bad_set_hms", {hou, min, sec}, 18'd0);
      step();
      check("bad_set_err_pulse", set_err, 0);

      // valid set on the base-tick cycle: set wins, second restarts
      budget = 12;
      while (m_psc != CLK - 1 && budget > 0) begin step(); budget--; end
      do_set(12, 34, 56);
      check("coin_hms", {hou, min, sec}, {6'd12, 6'd34, 6'd56});
      check("coin_tick", tick_1hz, 0);
      repeat (9) step();
      check("coin_hold", sec, 56);
      step();
      check("coin_next", sec, 57);

      // two slots at 07:00, lowest index wins
      do_wr(0, 7, 0, 1);
      do_wr(2, 7, 0, 1);
      do_set(6, 59, 59);
      repeat (10) step();
      check("alm_time", {hou, min, sec}, {6'd7, 6'd0, 6'd0});
      check("alm_ring_early", ring, 0);
      step();
      check("alm_ring", ring, 1);
      check("alm_idx", ring_idx, 0);
      cnt = 1; budget = 100;
      while (budget > 0) begin
         step(); budget--;
         if (ring) cnt++; else break;
      end
      check("ring_timeout", ring, 0);
      check("ring_len", cnt, CLK * RS - 1);

      // snooze across midnight
      do_wr(1, 23, 58, 1);
      do_set(23, 57, 59);
      repeat (11) step();
      check("snz_ring0", ring, 1);
      check("snz_idx0", ring_idx, 1);
      snooze = 1'b1; step(); snooze = 1'b0;
      check("snz_off", ring, 0);
      do_set(0, 2, 59);
      repeat (10) step();
      check("snz_time", {hou, min, sec}, {6'd0, 6'd3, 6'd0});
      check("snz_quiet", ring, 0);
      step();
      check("snz_again", ring, 1);
      check("snz_idx", ring_idx, 1);

      // dismiss beats snooze
      dismiss = 1'b1; snooze = 1'b1; step(); dismiss = 1'b0; snooze = 1'b0;
      check("ds_ring", ring, 0);
      do_set(0, 7, 59);
      repeat (11) step();
      check("ds_no_resnooze", ring, 0);

      // another alarm matching while ringing is ignored
      do_set(6, 59, 59);
      repeat (11) step();
      check("ign_ring0", ring, 1);
      do_wr(1, 7, 1, 1);
      do_set(7, 1, 0);
      step();
      check("ign_ring", ring, 1);
      check("ign_idx", ring_idx, 0);

      // stop freezes time but not the ring timeout
      stop = 1'b1;
      budget = 60;
      while (ring && budget > 0) begin step(); budget--; end
      check("stop_ring_off", ring, 0);
      check("stop_frozen", {hou, min, sec}, {6'd7, 6'd1, 6'd0});
      stop = 1'b0;

      // rejected alarm writes
      do_wr(3, 8, 0, 0);
      check("bad_idx_err", set_err, 1);
      check("bad_idx_en", alarm_en, 3'b111);
      do_wr(0, 24, 0, 0);
      check("bad_hou_err", set_err, 1);
      check("bad_hou_en", alarm_en, 3'b111);

      // reset mid-operation clears slots
      rst_n = 1'b1; step(); rst_n = 1'b0;
      check("midrst_en", alarm_en, 0);
      check("midrst_hms", {hou, min, sec}, 18'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 199) == 0) stop = ~stop;
         if ($urandom_range(0, 59) == 0) begin
            set_time = 1'b1;
            hou_in = 6'(pick_hou());
            min_in = 6'(pick_min());
            sec_in = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(57, 60)) : 6'($urandom_range(0, 63));
         end
         if ($urandom_range(0, 79) == 0) begin
            alarm_wr = 1'b1;
            alarm_idx = 2'($urandom_range(0, 3));
            alarm_hou = 6'(pick_hou());
            alarm_min = 6'(pick_min());
            alarm_en_in = ($urandom_range(0, 3) != 0);
         end
         snooze  = ($urandom_range(0, 39) == 0);
         dismiss = ($urandom_range(0, 59) == 0);
         step();
         rst_n = 1'b0; set_time = 1'b0; alarm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
